mage_subscript_gen: RTL and testbench

- Sequential producer of per-dimension subscripts for the flat address generator.
- Walks a 2-deep loop nest (dimension 0 outer, dimension N_SUBSCRIPTS-1 inner).
- Each element is emitted over a valid/ready stream as subscript_k = base_k + iv_k*stride_k.
- Sits between the loop-configuration registers and the flat address adder in the access path.
- Products are formed by stride accumulation; the block contains no multipliers.

---
 rtl/mage_pkg.sv | 38 +++
 rtl/mage_loop_dim.sv | 55 +++++
 rtl/mage_subscript_gen.sv | 131 +++++++++++++
 tb/tb_mage_subscript_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mage_pkg.sv
// -----------------------------------------------------------------------------
// mage_pkg
// Shared widths and types for the MAGE address-generation blocks.
//   N_SUBSCRIPTS   : number of loop dimensions / subscripts.
//   NBIT_FLAT_ADDR : subscript and flat address width.
//   NBIT_LOOP_ITER : width of each iteration bound and counter.
//   loop_cfg_t     : per-dimension loop configuration {base, stride, bound}.
//   sgen_state_e   : subscript generator control states.
// -----------------------------------------------------------------------------
package mage_pkg;

   localparam int N_SUBSCRIPTS   = 2;
   localparam int NBIT_FLAT_ADDR = 8;
   localparam int NBIT_LOOP_ITER = 8;

   localparam logic [NBIT_LOOP_ITER-1:0] ITER_ONE = NBIT_LOOP_ITER'(1);

   typedef struct packed {
      logic [NBIT_FLAT_ADDR-1:0] base;
      logic [NBIT_FLAT_ADDR-1:0] stride;
      logic [NBIT_LOOP_ITER-1:0] bound;
   } loop_cfg_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sgen_state_e;

   // Address addition wraps modulo 2^NBIT_FLAT_ADDR.
   function automatic logic [NBIT_FLAT_ADDR-1:0] addr_add(
      input logic [NBIT_FLAT_ADDR-1:0] a,
      input logic [NBIT_FLAT_ADDR-1:0] b
   );
      return a + b;
   endfunction

endpackage

// File: rtl/mage_loop_dim.sv
// -----------------------------------------------------------------------------
// mage_loop_dim
// One dimension of the loop nest: an iteration counter plus a subscript
// accumulator (subscript = base + iv*stride built by repeated addition).
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset.
//   load         : capture base/stride/bound, iv -> 0, subscript -> base.
//   advance      : step this dimension (wraps to base after bound-1).
//   base, stride, bound : configuration sampled on load.
//   subscript    : current subscript value.
//   at_end       : iv equals bound-1 (the next advance wraps).
// -----------------------------------------------------------------------------
module mage_loop_dim
   import mage_pkg::*;
(
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      load,
   input  logic                      advance,
   input  logic [NBIT_FLAT_ADDR-1:0] base,
   input  logic [NBIT_FLAT_ADDR-1:0] stride,
   input  logic [NBIT_LOOP_ITER-1:0] bound,
   output logic [NBIT_FLAT_ADDR-1:0] subscript,
   output logic                      at_end
);

   loop_cfg_t                 cfg_q;
   logic [NBIT_LOOP_ITER-1:0] iv_q;
   logic [NBIT_FLAT_ADDR-1:0] acc_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cfg_q <= '0;
         iv_q  <= '0;
         acc_q <= '0;
      end else if (load) begin
         cfg_q <= '{base: base, stride: stride, bound: bound};
         iv_q  <= '0;
         acc_q <= base;
      end else if (advance) begin
         if (at_end) begin
            iv_q  <= '0;
            acc_q <= cfg_q.base;
         end else begin
            iv_q  <= iv_q + ITER_ONE;
            acc_q <= addr_add(acc_q, cfg_q.stride);
         end
      end
   end

   // A zero bound never reaches RUN, so bound-1 underflow is never observed.
   assign at_end    = (iv_q == (cfg_q.bound - ITER_ONE));
   assign subscript = acc_q;

endmodule

// File: rtl/mage_subscript_gen.sv
// -----------------------------------------------------------------------------
// mage_subscript_gen
// Walks an N_SUBSCRIPTS-deep loop nest (dimension 0 outermost) and streams
// subscript_k = base_k + iv_k*stride_k over a valid/ready interface, one
// element per cycle at full throughput. No multipliers: each dimension
// accumulates its stride.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset.
//   clear_i        : synchronous abort back to IDLE (discards offered element).
//   start_i        : launch, sampled only in IDLE; latches base/stride/bound.
//   base_i, stride_i, bound_i : per-dimension configuration.
//   subscripts_o   : current subscripts, valid_o qualifies.
//   valid_o/ready_i: stream handshake; last_o marks the final element.
//   busy_o         : in RUN.   done_o : one-cycle pulse at end of the nest.
// Optional build macro MAGE_SUBSCRIPT_GEN_PERF_EN adds stall_cnt_o, a
// saturating 32-bit count of cycles with valid_o && !ready_i.
// -----------------------------------------------------------------------------
module mage_subscript_gen
   import mage_pkg::*;
(
   input  logic                                          clk_i,
   input  logic                                          rst_i,
   input  logic                                          clear_i,
   input  logic                                          start_i,
   input  logic [N_SUBSCRIPTS-1:0][NBIT_FLAT_ADDR-1:0]   base_i,
   input  logic [N_SUBSCRIPTS-1:0][NBIT_FLAT_ADDR-1:0]   stride_i,
   input  logic [N_SUBSCRIPTS-1:0][NBIT_LOOP_ITER-1:0]   bound_i,
   output logic [N_SUBSCRIPTS-1:0][NBIT_FLAT_ADDR-1:0]   subscripts_o,
   output logic                                          valid_o,
   input  logic                                          ready_i,
   output logic                                          last_o,
   output logic                                          busy_o,
`ifdef MAGE_SUBSCRIPT_GEN_PERF_EN
   output logic [31:0]                                   stall_cnt_o,
`endif
   output logic                                          done_o
);

   sgen_state_e             state_q, state_d;
   logic                    load;
   logic                    xfer;
   logic                    any_zero;
   logic [N_SUBSCRIPTS-1:0] adv;
   logic [N_SUBSCRIPTS-1:0] at_end;

   assign valid_o = (state_q == RUN);
   assign busy_o  = (state_q == RUN);
   assign done_o  = (state_q == DONE);
   assign last_o  = valid_o && (&at_end);
   assign xfer    = valid_o && ready_i;

   always_comb begin
      any_zero = 1'b0;
      for (int k = 0; k < N_SUBSCRIPTS; k++) begin
         if (bound_i[k] == '0) any_zero = 1'b1;
      end
   end

   // Innermost dimension steps on every accepted element; each outer one
   // steps only when everything inside it wraps. clear_i discards the element.
   always_comb begin
      adv                 = '0;
      adv[N_SUBSCRIPTS-1] = xfer && !clear_i;
      for (int k = N_SUBSCRIPTS-2; k >= 0; k--) begin
         adv[k] = adv[k+1] && at_end[k+1];
      end
   end

   for (genvar k = 0; k < N_SUBSCRIPTS; k++) begin : g_dim
      mage_loop_dim u_dim (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .load      (load),
         .advance   (adv[k]),
         .base      (base_i[k]),
         .stride    (stride_i[k]),
         .bound     (bound_i[k]),
         .subscript (subscripts_o[k]),
         .at_end    (at_end[k])
      );
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               load    = 1'b1;
               state_d = any_zero ? DONE : RUN;
            end
         end
         RUN: begin
            if (xfer && last_o) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (clear_i) begin
         load    = 1'b0;
         state_d = IDLE;
      end
   end

`ifdef MAGE_SUBSCRIPT_GEN_PERF_EN
   localparam logic [31:0] STALL_ONE = 32'd1;
   logic [31:0] stall_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_q <= '0;
      end else if (load) begin
         stall_q <= '0;
      end else if (valid_o && !ready_i && (stall_q != '1)) begin
         stall_q <= stall_q + STALL_ONE;
      end
   end

   assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_mage_subscript_gen.sv
// -----------------------------------------------------------------------------
// tb_mage_subscript_gen
// Scoreboard bench: launches push the full expected element list (computed
// with nested loops and plain arithmetic); a negedge monitor pops and compares
// every accepted element, checks hold-stability under stall and the done pulse.
// -----------------------------------------------------------------------------
module tb_mage_subscript_gen;
   import mage_pkg::*;

   typedef struct {
      logic [N_SUBSCRIPTS-1:0][NBIT_FLAT_ADDR-1:0] s;
      logic                                        l;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, clear, start, ready;
   logic [N_SUBSCRIPTS-1:0][NBIT_FLAT_ADDR-1:0] base, stride, subs;
   logic [N_SUBSCRIPTS-1:0][NBIT_LOOP_ITER-1:0] bound;
   logic valid, last, busy, done;
`ifdef MAGE_SUBSCRIPT_GEN_PERF_EN
   logic [31:0] stall_cnt;
   int          stall_model;
`endif

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   xfer_cnt;
   logic done_pend;
   logic zero_arm;
   logic prev_stall;
   logic [N_SUBSCRIPTS-1:0][NBIT_FLAT_ADDR-1:0] prev_subs;
   logic prev_last;

   mage_subscript_gen dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .clear_i      (clear),
      .start_i      (start),
      .base_i       (base),
      .stride_i     (stride),
      .bound_i      (bound),
      .subscripts_o (subs),
      .valid_o      (valid),
      .ready_i      (ready),
      .last_o       (last),
      .busy_o       (busy),
`ifdef MAGE_SUBSCRIPT_GEN_PERF_EN
      .stall_cnt_o  (stall_cnt),
`endif
      .done_o       (done)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: decides at the negedge what the next posedge will transfer.
   always @(negedge clk) begin
      logic nxt;
      exp_t e;
      nxt = 1'b0;
      if (rst) begin
         done_pend  = 1'b0;
         zero_arm   = 1'b0;
         prev_stall = 1'b0;
      end else begin
         if (done_pend || done) check("done_pulse", {63'd0, done}, {63'd0, done_pend});
         if (zero_arm) begin
            nxt      = !clear;
            zero_arm = 1'b0;
         end
         if (prev_stall && valid) begin
            check("hold_subs", {48'd0, subs}, {48'd0, prev_subs});
            check("hold_last", {63'd0, last}, {63'd0, prev_last});
         end
         if (valid && ready && !clear) begin
            if (q.size() == 0) begin
               check("unexpected_xfer", 64'd1, 64'd0);
            end else begin
               e = q.pop_front();
               check("subs", {48'd0, subs}, {48'd0, e.s});
               check("last", {63'd0, last}, {63'd0, e.l});
               if (e.l) nxt = 1'b1;
            end
            xfer_cnt++;
         end
`ifdef MAGE_SUBSCRIPT_GEN_PERF_EN
         if (valid && !ready) stall_model++;
`endif
         prev_stall = valid && !ready && !clear;
         prev_subs  = subs;
         prev_last  = last;
         done_pend  = nxt;
      end
   end

   task automatic launch(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] n0, input logic [7:0] n1);
      exp_t e;
      base[0] = b0; base[1] = b1;
      stride[0] = s0; stride[1] = s1;
      bound[0] = n0; bound[1] = n1;
      xfer_cnt = 0;
`ifdef MAGE_SUBSCRIPT_GEN_PERF_EN
      stall_model = 0;
`endif
      if (n0 == 0 || n1 == 0) begin
         zero_arm = 1'b1;
      end else begin
         for (int i0 = 0; i0 < int'(n0); i0++) begin
            for (int i1 = 0; i1 < int'(n1); i1++) begin
               e.s[0] = NBIT_FLAT_ADDR'(int'(b0) + i0 * int'(s0));
               e.s[1] = NBIT_FLAT_ADDR'(int'(b1) + i1 * int'(s1));
               e.l    = (i0 == int'(n0) - 1) && (i1 == int'(n1) - 1);
               q.push_back(e);
            end
         end
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      // Scramble the inputs: the running nest must use the latched copy.
      base   = NBIT_FLAT_ADDR'($urandom) == 0 ? '1 : {N_SUBSCRIPTS{NBIT_FLAT_ADDR'($urandom)}};
      stride = {N_SUBSCRIPTS{NBIT_FLAT_ADDR'($urandom)}};
      bound  = {N_SUBSCRIPTS{NBIT_LOOP_ITER'($urandom_range(1, 9))}};
   endtask

   // mode 0: ready always 1; 1: pattern 1,0,0 repeating; 2: random
   task automatic run_to_done(input int mode);
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         case (mode)
            0:       ready = 1'b1;
            1:       ready = (c % 3 == 0);
            default: ready = 1'($urandom_range(0, 1));
         endcase
         tick();
      end
      check("done_seen", {63'd0, seen}, 64'd1);
      check("queue_drained", 64'(q.size()), 64'd0);
`ifdef MAGE_SUBSCRIPT_GEN_PERF_EN
      check("stall_cnt", {32'd0, stall_cnt}, 64'(stall_model));
`endif
      ready = 1'b1;
      tick();
      check("idle_busy", {63'd0, busy}, 64'd0);
      check("idle_done", {63'd0, done}, 64'd0);
      check("idle_valid", {63'd0, valid}, 64'd0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_valid"}, {63'd0, valid}, 64'd0);
      check({tag, "_last"}, {63'd0, last}, 64'd0);
      check({tag, "_busy"}, {63'd0, busy}, 64'd0);
      check({tag, "_done"}, {63'd0, done}, 64'd0);
      check({tag, "_subs"}, {48'd0, subs}, 64'd0);
   endtask

   initial begin
      logic [7:0] r0, r1;
      rst = 1'b1; clear = 1'b0; start = 1'b0; ready = 1'b0;
      base = '0; stride = '0; bound = '0;
      xfer_cnt = 0; done_pend = 1'b0; zero_arm = 1'b0; prev_stall = 1'b0;
      prev_subs = '0; prev_last = 1'b0;
`ifdef MAGE_SUBSCRIPT_GEN_PERF_EN
      stall_model = 0;
`endif
      tick(); tick();
      check_zero_outputs("reset");
      rst = 1'b0;
      tick();

      // Basic nest, full throughput
      launch(8'd0, 8'd100, 8'd10, 8'd1, 8'd2, 8'd3);
      run_to_done(0);

      // Backpressure 1,0,0,...
      launch(8'd0, 8'd100, 8'd10, 8'd1, 8'd2, 8'd3);
      run_to_done(1);

      // Zero bound: no element, done pulse, back to IDLE
      launch(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd4);
      run_to_done(0);

      // Wrap-around of the inner subscript
      launch(8'd0, 8'd250, 8'd0, 8'd3, 8'd1, 8'd4);
      run_to_done(2);

      // Maximum bound on the inner dimension
      launch(8'd7, 8'd0, 8'd1, 8'd1, 8'd1, 8'd255);
      run_to_done(0);

      // Abort after the second transfer
      launch(8'd0, 8'd100, 8'd10, 8'd1, 8'd2, 8'd3);
      ready = 1'b1;
      for (int c = 0; c < 20 && xfer_cnt < 2; c++) tick();
      check("abort_two_xfers", 64'(xfer_cnt), 64'd2);
      clear = 1'b1;
      q.delete();
      tick();
      clear = 1'b0;
      check("abort_valid", {63'd0, valid}, 64'd0);
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_done", {63'd0, done}, 64'd0);
      tick();
      check("abort_done_late", {63'd0, done}, 64'd0);
      launch(8'd0, 8'd100, 8'd10, 8'd1, 8'd2, 8'd3);
      run_to_done(0);

      // Reset mid-run, start held during reset is ignored
      launch(8'd3, 8'd5, 8'd7, 8'd9, 8'd4, 8'd5);
      ready = 1'b1;
      tick(); tick(); tick();
      rst = 1'b1;
      start = 1'b1;
      #1;
      check_zero_outputs("rst_async");
      q.delete();
      tick();
      check_zero_outputs("rst_held");
      rst = 1'b0;
      start = 1'b0;
      tick();
      check("rst_no_start", {63'd0, valid}, 64'd0);
      launch(8'd0, 8'd100, 8'd10, 8'd1, 8'd2, 8'd3);
      run_to_done(1);

      // Randomized configurations
      for (int t = 0; t < 30; t++) begin
         r0 = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 5));
         r1 = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
         launch(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), r0, r1);
         run_to_done(t % 3);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
